// File: rtl/fizzbuzz_gen.sv
// fizzbuzz_gen: walks 1..LIMIT on a start pulse and streams each value with
// fizz (n%3==0) and buzz (n%5==0) flags on a valid/ready handshake.
// Ports: clk, rst_n (sync, active-low), start, busy, done,
//        out_valid/out_ready/out_value/out_fizz/out_buzz stream,
//        fizzbuzz_count (only when FIZZBUZZ_GEN_STATS_EN is defined).
// Divisibility comes from wrap-around mod-3/mod-5 counters, not dividers.
module fizzbuzz_gen #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_fizz,
  output logic             out_buzz
`ifdef FIZZBUZZ_GEN_STATS_EN
  ,
  output logic [WIDTH-1:0] fizzbuzz_count
`endif
);

  if (LIMIT < 1 || longint'(LIMIT) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_limit
    $error("fizzbuzz_gen: LIMIT out of range for WIDTH");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] n;
  logic [1:0]       mod3;
  logic [2:0]       mod5;
  logic             xfer;
  logic             last;

  assign out_valid = (state == S_RUN);
  assign busy      = out_valid;
  assign done      = (state == S_DONE);
  assign out_value = n;
  // Gated by valid so the flags read 0 at reset (counters are 0 there).
  assign out_fizz  = out_valid && (mod3 == 2'd0);
  assign out_buzz  = out_valid && (mod5 == 3'd0);
  assign xfer      = out_valid && out_ready;
  assign last      = (n == LIM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      n     <= '0;
      mod3  <= 2'd0;
      mod5  <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            n     <= ONE;
            mod3  <= 2'd1;
            mod5  <= 3'd1;
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (last) begin
              state <= S_DONE;
            end else begin
              n    <= n + ONE;
              mod3 <= (mod3 == 2'd2) ? 2'd0 : mod3 + 2'd1;
              mod5 <= (mod5 == 3'd4) ? 3'd0 : mod5 + 3'd1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FIZZBUZZ_GEN_STATS_EN
  // Cleared by an accepted start, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fizzbuzz_count <= '0;
    end else if (state == S_IDLE && start) begin
      fizzbuzz_count <= '0;
    end else if (xfer && out_fizz && out_buzz && fizzbuzz_count != '1) begin
      fizzbuzz_count <= fizzbuzz_count + ONE;
    end
  end
`endif

endmodule

// File: tb/tb_fizzbuzz_gen.sv
// tb_fizzbuzz_gen: table-driven check of fizzbuzz_gen with LIMIT=15, LIMIT=1
// and LIMIT=100 instances; full rate, random backpressure, ignored start, reset.
module tb_fizzbuzz_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // LIMIT=15 instance
  logic       start, out_ready;
  logic       busy, done, out_valid, out_fizz, out_buzz;
  logic [7:0] out_value;
  // LIMIT=1 instance
  logic       start1, ready1;
  logic       busy1, done1, valid1, fizz1, buzz1;
  logic [7:0] value1;
  // LIMIT=100 instance
  logic       start100, ready100;
  logic       busy100, done100, valid100, fizz100, buzz100;
  logic [7:0] value100;
`ifdef FIZZBUZZ_GEN_STATS_EN
  logic [7:0] cnt15, cnt100;
`endif

  fizzbuzz_gen #(.WIDTH(8), .LIMIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_fizz(out_fizz), .out_buzz(out_buzz)
`ifdef FIZZBUZZ_GEN_STATS_EN
    , .fizzbuzz_count(cnt15)
`endif
  );

  fizzbuzz_gen #(.WIDTH(8), .LIMIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .out_valid(valid1), .out_ready(ready1), .out_value(value1),
    .out_fizz(fizz1), .out_buzz(buzz1)
`ifdef FIZZBUZZ_GEN_STATS_EN
    , .fizzbuzz_count()
`endif
  );

  fizzbuzz_gen #(.WIDTH(8), .LIMIT(100)) dut100 (
    .clk(clk), .rst_n(rst_n), .start(start100), .busy(busy100),
    .done(done100), .out_valid(valid100), .out_ready(ready100),
    .out_value(value100), .out_fizz(fizz100), .out_buzz(buzz100)
`ifdef FIZZBUZZ_GEN_STATS_EN
    , .fizzbuzz_count(cnt100)
`endif
  );

  typedef struct {
    int val;
    bit fizz;
    bit buzz;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs the LIMIT=15 instance. poke: value at which start is re-pulsed.
  // abort: value at which reset is asserted (0 = never).
  task automatic run15(input bit rnd, input int poke, input int abort);
    int idx = 0;
    int cyc = 0;
    bit held = 0;
    int hv = 0;
    bit hf = 0, hb = 0;
    bit rdy;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("first_valid", int'(out_valid), 1);
    chk("first_busy", int'(busy), 1);
    while (idx < 15 && cyc < 400) begin
      if (held) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_value", int'(out_value), hv);
        chk("hold_flags", int'({out_fizz, out_buzz}), int'({hf, hb}));
      end
      if (abort != 0 && int'(out_value) == abort) begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_value", int'(out_value), 0);
        chk("abort_flags", int'({out_fizz, out_buzz}), 0);
        rst_n = 1'b1;
        out_ready = 1'b0;
        tick();
        chk("abort_no_done", int'(done), 0);
        chk("abort_idle", int'(out_valid), 0);
        return;
      end
      start = (int'(out_value) == poke);
      rdy = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      out_ready = rdy;
      if (out_valid && rdy) begin
        chk("value", int'(out_value), tbl[idx].val);
        chk("fizz", int'(out_fizz), int'(tbl[idx].fizz));
        chk("buzz", int'(out_buzz), int'(tbl[idx].buzz));
        idx++;
        held = 0;
      end else begin
        held = out_valid;
        hv = int'(out_value);
        hf = out_fizz;
        hb = out_buzz;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk("transfers", idx, 15);
    chk("done_pulse", int'(done), 1);
    chk("done_valid", int'(out_valid), 0);
    tick();
    chk("done_cleared", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    int n100;
    int to;
    tbl[0]  = '{1, 0, 0};  tbl[1]  = '{2, 0, 0};  tbl[2]  = '{3, 1, 0};
    tbl[3]  = '{4, 0, 0};  tbl[4]  = '{5, 0, 1};  tbl[5]  = '{6, 1, 0};
    tbl[6]  = '{7, 0, 0};  tbl[7]  = '{8, 0, 0};  tbl[8]  = '{9, 1, 0};
    tbl[9]  = '{10, 0, 1}; tbl[10] = '{11, 0, 0}; tbl[11] = '{12, 1, 0};
    tbl[12] = '{13, 0, 0}; tbl[13] = '{14, 0, 0}; tbl[14] = '{15, 1, 1};

    start = 1'b1; start1 = 1'b1; start100 = 1'b1;
    out_ready = 1'b0; ready1 = 1'b0; ready100 = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    start = 1'b0; start1 = 1'b0; start100 = 1'b0;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_value", int'(out_value), 0);
    chk("rst_flags", int'({out_fizz, out_buzz}), 0);
`ifdef FIZZBUZZ_GEN_STATS_EN
    chk("rst_count", int'(cnt15), 0);
`endif
    tick();
    chk("idle_stays", int'(out_valid), 0);

    run15(1'b0, 0, 0);
`ifdef FIZZBUZZ_GEN_STATS_EN
    chk("count15", int'(cnt15), 1);
`endif
    run15(1'b1, 0, 0);
    run15(1'b0, 7, 0);
    run15(1'b0, 0, 9);
    run15(1'b0, 0, 0);

    // LIMIT=1
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("l1_valid", int'(valid1), 1);
    chk("l1_busy", int'(busy1), 1);
    chk("l1_value", int'(value1), 1);
    chk("l1_flags", int'({fizz1, buzz1}), 0);
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    chk("l1_done", int'(done1), 1);
    chk("l1_off", int'(valid1), 0);
    tick();
    chk("l1_done_clr", int'(done1), 0);

    // LIMIT=100 full run
    start100 = 1'b1;
    tick();
    start100 = 1'b0;
    ready100 = 1'b1;
    n100 = 0;
    to = 0;
    while (!done100 && to < 300) begin
      if (valid100) begin
        n100++;
        if (int'(value100) == 15) chk("l100_fb15", int'({fizz100, buzz100}), 3);
        if (int'(value100) == 100) chk("l100_buzz100", int'({fizz100, buzz100}), 1);
      end
      tick();
      to++;
    end
    ready100 = 1'b0;
    chk("l100_transfers", n100, 100);
    chk("l100_done", int'(done100), 1);
    chk("l100_last", int'(value100), 100);
`ifdef FIZZBUZZ_GEN_STATS_EN
    chk("count100", int'(cnt100), 6);
    tick();
    chk("count_hold", int'(cnt100), 6);
    start100 = 1'b1;
    tick();
    start100 = 1'b0;
    chk("count_clear", int'(cnt100), 0);
    ready100 = 1'b1;
    to = 0;
    while (int'(value100) != 15 && to < 50) begin
      tick();
      to++;
    end
    chk("count_pre15", int'(cnt100), 0);
    tick();
    chk("count_post15", int'(cnt100), 1);
    ready100 = 1'b0;
`else
    tick();
`endif
    chk("l100_busy_end", int'(busy100), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
